// File: rtl/io_switch_debouncer.sv
// Synchronises and debounces SW0, SW1 and PB0 for the IO input port.
// Also produces a PB0 press pulse and a sticky press flag that software polls.
module io_switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sw0_raw,
   input  logic sw1_raw,
   input  logic pb0_raw,
   input  logic pb0_ack,
   output logic io_sw0,
   output logic io_sw1,
   output logic io_pb0,
   output logic pb0_press,
   output logic pb0_latched
);

   localparam int NCH = 3;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   // Channel index matches the port bit: 0 = PB0, 1 = SW0, 2 = SW1.
   logic [NCH-1:0]       raw;
   logic [NCH-1:0]       sync1;
   logic [NCH-1:0]       sync2;
   logic [NCH-1:0]       stable;
   logic [NCH-1:0]       stable_next;
   logic [CNT_WIDTH-1:0] cnt      [NCH];
   logic [CNT_WIDTH-1:0] cnt_next [NCH];
   logic                 pb0_rise;
   logic                 latched_next;

   assign raw = {sw1_raw, sw0_raw, pb0_raw};

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      stable_next = stable;
      for (int i = 0; i < NCH; i++) begin
         cnt_next[i] = '0;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_MAX) begin
               stable_next[i] = sync2[i];
            end else begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // A press completes on the edge where the debounced PB0 level flips to 1.
   assign pb0_rise = stable_next[0] & ~stable[0];

   // Set beats ack so a press arriving with an acknowledge is never lost.
   always_comb begin
      latched_next = pb0_latched;
      if (pb0_rise) begin
         latched_next = 1'b1;
      end else if (pb0_ack) begin
         latched_next = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1       <= '0;
         sync2       <= '0;
         stable      <= '0;
         pb0_press   <= 1'b0;
         pb0_latched <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1       <= raw;
         sync2       <= sync1;
         stable      <= stable_next;
         pb0_press   <= pb0_rise;
         pb0_latched <= latched_next;
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   assign io_pb0 = stable[0];
   assign io_sw0 = stable[1];
   assign io_sw1 = stable[2];

endmodule

// File: tb/tb_io_switch_debouncer.sv
// Directed bench for io_switch_debouncer with DEBOUNCE_CYCLES=4.
// Stimulus pushes hand-computed expected outputs; a monitor pops and compares after each edge.
module tb_io_switch_debouncer;

   localparam int DEB = 4;

   typedef struct {
      logic [4:0] exp;
      string      name;
   } exp_t;

   logic clock;
   logic reset_n;
   logic sw0_raw, sw1_raw, pb0_raw, pb0_ack;
   logic io_sw0, io_sw1, io_pb0, pb0_press, pb0_latched;

   exp_t       sb[$];
   logic [4:0] cur_exp;
   int         total;
   int         bad;

   io_switch_debouncer #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_WIDTH      (16)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .sw0_raw    (sw0_raw),
      .sw1_raw    (sw1_raw),
      .pb0_raw    (pb0_raw),
      .pb0_ack    (pb0_ack),
      .io_sw0     (io_sw0),
      .io_sw1     (io_sw1),
      .io_pb0     (io_pb0),
      .pb0_press  (pb0_press),
      .pb0_latched(pb0_latched)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Output vector order: {io_sw0, io_sw1, io_pb0, pb0_press, pb0_latched}.
   function automatic logic [4:0] outs();
      return {io_sw0, io_sw1, io_pb0, pb0_press, pb0_latched};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Applies the current inputs across one rising edge; cur_exp is the state after that edge.
   task automatic run(input int n, input string name);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.exp  = cur_exp;
         e.name = name;
         sb.push_back(e);
         @(posedge clock);
         #3;
      end
   endtask

   // Monitor: compares once per edge whenever an expectation is pending.
   always @(posedge clock) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.name, 32'(outs()), 32'(e.exp));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] bounce;
      total = 0;
      bad   = 0;
      bounce = 10'b1111110111;

      // Test 1: reset with all raw inputs high, then release.
      sw0_raw = 1'b1; sw1_raw = 1'b1; pb0_raw = 1'b1; pb0_ack = 1'b0;
      reset_n = 1'b0;
      cur_exp = 5'b00000;
      #3;
      check("t1_reset_async", 32'(outs()), 32'd0);
      run(2, "t1_in_reset");
      reset_n = 1'b1;
      run(DEB + 1, "t1_pre");
      cur_exp = 5'b11111; run(1, "t1_rise");
      cur_exp = 5'b11101; run(1, "t1_hold");
      sw0_raw = 1'b0; sw1_raw = 1'b0; pb0_raw = 1'b0;
      run(DEB + 1, "t1_fall_pre");
      cur_exp = 5'b00001; run(1, "t1_fall");
      pb0_ack = 1'b1;
      cur_exp = 5'b00000; run(1, "t1_ack");
      pb0_ack = 1'b0;

      // Test 2: clean step on SW1.
      sw1_raw = 1'b1;
      run(DEB + 1, "t2_pre");
      cur_exp = 5'b01000; run(1, "t2_rise");
      run(2, "t2_hold");

      // Test 3: SW0 bounce 1,1,1,0,1,1,1,1 then held high.
      for (int i = 0; i < 10; i++) begin
         sw0_raw = bounce[i];
         cur_exp = (i == 9) ? 5'b11000 : 5'b01000;
         run(1, "t3_bounce");
      end
      run(1, "t3_hold");

      // Test 4: PB0 press, ack, release.
      pb0_raw = 1'b1;
      run(DEB + 1, "t4_pre");
      cur_exp = 5'b11111; run(1, "t4_press");
      cur_exp = 5'b11101; run(3, "t4_held");
      pb0_ack = 1'b1;
      cur_exp = 5'b11100; run(1, "t4_ack");
      pb0_ack = 1'b0;
      pb0_raw = 1'b0;
      run(DEB + 1, "t4_rel_pre");
      cur_exp = 5'b11000; run(1, "t4_release");
      run(1, "t4_no_pulse");

      // Test 5: ack on the same edge a press completes.
      pb0_raw = 1'b1;
      run(DEB + 1, "t5_pre");
      pb0_ack = 1'b1;
      cur_exp = 5'b11111; run(1, "t5_collide");
      pb0_ack = 1'b0;
      cur_exp = 5'b11101; run(1, "t5_after");
      pb0_ack = 1'b1;
      cur_exp = 5'b11100; run(1, "t5_clear");
      run(1, "t5_ack_idle");
      pb0_ack = 1'b0;

      // Test 6: reset in the middle of an SW0 count.
      sw0_raw = 1'b0; sw1_raw = 1'b0; pb0_raw = 1'b0;
      run(DEB + 1, "t6_clr_pre");
      cur_exp = 5'b00000; run(1, "t6_clr");
      sw0_raw = 1'b1;
      run(3, "t6_count");
      reset_n = 1'b0;
      #1;
      check("t6_reset_async", 32'(outs()), 32'd0);
      run(1, "t6_in_reset");
      reset_n = 1'b1;
      run(DEB + 1, "t6_pre");
      cur_exp = 5'b10000; run(1, "t6_rise");
      run(1, "t6_hold");

      @(posedge clock);
      #4;
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
